// File: rtl/aes_gf_pkg.sv
// Shared GF(2^8) definitions for the AES round datapath: byte width,
// reduction constant, coefficient-select encoding and the xtime primitive.
package aes_gf_pkg;

    localparam int         BYTE_SIZE = 8;
    localparam logic [7:0] IR        = 8'h1B;

    typedef enum logic [2:0] {
        MODE_01   = 3'd0,
        MODE_02   = 3'd1,
        MODE_03   = 3'd2,
        MODE_09   = 3'd3,
        MODE_0B   = 3'd4,
        MODE_0D   = 3'd5,
        MODE_0E   = 3'd6,
        MODE_RSVD = 3'd7
    } gf_mode_e;

    // Multiply by x (02) in GF(2^8), folding the overflowed MSB back in via ir.
    function automatic logic [7:0] xtime(input logic [7:0] b, input logic [7:0] ir);
        return {b[6:0], 1'b0} ^ (b[7] ? ir : 8'h00);
    endfunction

endpackage

// File: rtl/gf_pipe_stage.sv
// Generic valid/ready register slice: accepts a beat when empty or when the
// held beat is leaving in the same cycle, so a chain of slices runs at full rate.
module gf_pipe_stage #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data
);

    logic                  valid_q;
    logic [DATA_WIDTH-1:0] data_q;

    assign in_ready = !valid_q || out_ready;

    // NOTE: state updates use non-blocking assignments so every stage samples
    // its neighbour's pre-edge value and the chain shifts as one register file.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            // NOTE: the payload is reset too, because the block's outputs must
            // read all-zero after reset, not just be marked invalid.
            data_q  <= '0;
        end else begin
            if (in_ready) begin
                valid_q <= in_valid;
            end
            if (in_valid && in_ready) begin
                data_q <= in_data;
            end
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/gf_mul_const_pipe.sv
// Multi-lane 3-stage GF(2^8) multiply-by-constant unit for (Inv)MixColumns.
// Define GF_MUL_INV_EN to build the InvMixColumns coefficients 09/0B/0D/0E.
module gf_mul_const_pipe #(
    parameter int         BYTE_SIZE = aes_gf_pkg::BYTE_SIZE,
    parameter int         LANES     = 4,
    parameter logic [7:0] IR        = aes_gf_pkg::IR
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [2:0]                   in_mode,
    input  logic [LANES*BYTE_SIZE-1:0]   in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [LANES*BYTE_SIZE-1:0]   out_data,
    output logic [2:0]                   out_mode,
    output logic                         mode_err
);

    import aes_gf_pkg::*;

    localparam int W  = LANES * BYTE_SIZE;
    localparam int MW = 3;
`ifdef GF_MUL_INV_EN
    localparam int S2_TERMS = 3;
`else
    // Only 01/02/03 are built, so x4 has no consumer and is not carried.
    localparam int S2_TERMS = 2;
`endif
    localparam int S1_W = MW + 2 * W;
    localparam int S2_W = MW + S2_TERMS * W;
    localparam int S3_W = MW + 1 + W;

    function automatic logic [W-1:0] xtime_lanes(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < LANES; i++) begin
            r[i*BYTE_SIZE +: BYTE_SIZE] = xtime(v[i*BYTE_SIZE +: BYTE_SIZE], IR);
        end
        return r;
    endfunction

    logic            v1, v2;
    logic            r2, r3;
    logic [S1_W-1:0] s1_d, s1_q;
    logic [S2_W-1:0] s2_d, s2_q;
    logic [S3_W-1:0] s3_d, s3_q;

    logic [2:0]      s1_mode, s2_mode;
    logic [W-1:0]    s1_a, s1_x2;
    logic [W-1:0]    s2_a, s2_x2;
    logic [W-1:0]    prod;
    logic            err;

    // Stage 1: operand and its first doubling.
    assign s1_d = {in_mode, in_data, xtime_lanes(in_data)};

    gf_pipe_stage #(.DATA_WIDTH(S1_W)) u_s1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (s1_d),
        .out_valid (v1),
        .out_ready (r2),
        .out_data  (s1_q)
    );

    assign {s1_mode, s1_a, s1_x2} = s1_q;

`ifdef GF_MUL_INV_EN
    logic [W-1:0] s1_x4, s2_x4, s2_x8;

    assign s1_x4 = xtime_lanes(s1_x2);
    assign s2_d  = {s1_mode, s1_a, s1_x2, s1_x4};
    assign {s2_mode, s2_a, s2_x2, s2_x4} = s2_q;
    assign s2_x8 = xtime_lanes(s2_x4);
`else
    assign s2_d  = {s1_mode, s1_a, s1_x2};
    assign {s2_mode, s2_a, s2_x2} = s2_q;
`endif

    gf_pipe_stage #(.DATA_WIDTH(S2_W)) u_s2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (v1),
        .in_ready  (r2),
        .in_data   (s2_d),
        .out_valid (v2),
        .out_ready (r3),
        .out_data  (s2_q)
    );

    // Whole-vector XOR is lane-local, so lanes never interact.
    always_comb begin
        // NOTE: defaults first so no path through the case leaves a variable
        // unassigned, which would otherwise infer a latch.
        prod = '0;
        err  = 1'b0;
        case (gf_mode_e'(s2_mode))
            MODE_01: prod = s2_a;
            MODE_02: prod = s2_x2;
            MODE_03: prod = s2_a ^ s2_x2;
`ifdef GF_MUL_INV_EN
            MODE_09: prod = s2_x8 ^ s2_a;
            MODE_0B: prod = s2_x8 ^ s2_x2 ^ s2_a;
            MODE_0D: prod = s2_x8 ^ s2_x4 ^ s2_a;
            MODE_0E: prod = s2_x8 ^ s2_x4 ^ s2_x2;
`endif
            default: err = 1'b1;
        endcase
    end

    assign s3_d = {s2_mode, err, prod};

    gf_pipe_stage #(.DATA_WIDTH(S3_W)) u_s3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (v2),
        .in_ready  (r3),
        .in_data   (s3_d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (s3_q)
    );

    assign {out_mode, mode_err, out_data} = s3_q;

endmodule

// File: tb/tb_gf_mul_const_pipe.sv
// Scoreboard bench for gf_mul_const_pipe: directed vectors, bursts, stalls,
// mid-flight reset and randomized traffic against a shift-and-add GF model.
module tb_gf_mul_const_pipe;

    localparam int LANES = 4;
    localparam int W     = LANES * 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [2:0]   in_mode = 3'd0;
    logic [W-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_data;
    logic [2:0]   out_mode;
    logic         mode_err;

    always #5 clk = ~clk;

    gf_mul_const_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_mode  (out_mode),
        .mode_err  (mode_err)
    );

    typedef struct {
        logic [W-1:0] data;
        logic [2:0]   mode;
        logic         err;
        int           acc_cyc;
        bit           lat;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_err  = 0;
    int   cyc    = 0;
    int   n_acc  = 0;
    int   n_out  = 0;
    int   n_wait = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: generic GF(2^8) shift-and-add multiply modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] c);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h00;
        p = a;
        for (int k = 0; k < 8; k++) begin
            if (c[k]) r = r ^ p;
            p = {p[6:0], 1'b0} ^ (p[7] ? 8'h1B : 8'h00);
        end
        return r;
    endfunction

    function automatic exp_t mk(input logic [W-1:0] d, input logic [2:0] m, input logic e);
        exp_t x;
        x.data = d;
        x.mode = m;
        x.err = e;
        x.acc_cyc = 0;
        x.lat = 1'b0;
        return x;
    endfunction

    function automatic exp_t model(input logic [W-1:0] d, input logic [2:0] m);
        logic [7:0]   coef;
        logic [W-1:0] r;
        bit           ok;
        case (m)
            3'd0: coef = 8'h01;
            3'd1: coef = 8'h02;
            3'd2: coef = 8'h03;
            3'd3: coef = 8'h09;
            3'd4: coef = 8'h0B;
            3'd5: coef = 8'h0D;
            3'd6: coef = 8'h0E;
            default: coef = 8'h00;
        endcase
        ok = (m != 3'd7);
`ifndef GF_MUL_INV_EN
        ok = ok && (m < 3'd3);
`endif
        r = '0;
        if (ok) begin
            for (int i = 0; i < LANES; i++) r[i*8 +: 8] = gf_mul(d[i*8 +: 8], coef);
        end
        return mk(r, m, !ok);
    endfunction

    // Present one beat from the next falling edge until accepted; the expected
    // response is queued at the moment of acceptance.
    task automatic send(input logic [W-1:0] d, input logic [2:0] m, input exp_t e, input bit lat);
        int waited;
        waited = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data = d;
        in_mode = m;
        #4;
        while (!in_ready && waited < 200) begin
            waited++;
            @(negedge clk);
            #4;
        end
        n_wait += waited;
        if (!in_ready) begin
            check("accept_timeout", 64'(in_ready), 64'(1));
            in_valid = 1'b0;
            return;
        end
        e.acc_cyc = cyc;
        e.lat = lat;
        exp_q.push_back(e);
        n_acc++;
    endtask

    task automatic send_model(input logic [W-1:0] d, input logic [2:0] m, input bit lat);
        send(d, m, model(d, m), lat);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        idle();
        while (exp_q.size() != 0 && k < 100) begin
            @(negedge clk);
            #4;
            k++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'(0));
    endtask

    // Monitor: pops the scoreboard on every output transfer and checks that a
    // stalled output beat does not change.
    logic        hold_pend = 1'b0;
    logic [35:0] hold_val  = '0;

    always begin
        exp_t e;
        @(negedge clk);
        #4;
        if (!rst_n) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend)
                check("stall_hold", 64'({out_mode, mode_err, out_data}), 64'(hold_val));
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 64'(out_valid), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", 64'(out_data), 64'(e.data));
                    check("out_mode", 64'(out_mode), 64'(e.mode));
                    check("mode_err", 64'(mode_err), 64'(e.err));
                    if (e.lat) check("latency", 64'(cyc - e.acc_cyc), 64'(3));
                end
            end
            hold_pend = out_valid && !out_ready;
            hold_val  = {out_mode, mode_err, out_data};
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int  base;
        int  out_before;
        bit  seen;
        bit  done;

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        #4;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_data", 64'(out_data), 64'(0));
        check("rst_out_mode", 64'(out_mode), 64'(0));
        check("rst_mode_err", 64'(mode_err), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #4;
        check("rst_in_ready", 64'(in_ready), 64'(1));

        // Directed single beats from the reference vectors.
        send(32'h80575757, 3'd1, mk(32'h1BAEAEAE, 3'd1, 1'b0), 1'b1);
        wait_drain();
        send(32'h80575757, 3'd2, mk(32'h9BF9F9F9, 3'd2, 1'b0), 1'b1);
        wait_drain();
        send(32'h57575757, 3'd0, mk(32'h57575757, 3'd0, 1'b0), 1'b1);
        wait_drain();
`ifdef GF_MUL_INV_EN
        send(32'h57575757, 3'd3, mk(32'hD9D9D9D9, 3'd3, 1'b0), 1'b1);
        wait_drain();
        send(32'h57575757, 3'd6, mk(32'h67676767, 3'd6, 1'b0), 1'b1);
        wait_drain();
        send(32'h57575757, 3'd4, mk(32'h77777777, 3'd4, 1'b0), 1'b1);
        wait_drain();
`else
        send(32'h57575757, 3'd3, mk(32'h00000000, 3'd3, 1'b1), 1'b1);
        wait_drain();
        send(32'h57575757, 3'd6, mk(32'h00000000, 3'd6, 1'b1), 1'b1);
        wait_drain();
        send(32'h57575757, 3'd4, mk(32'h00000000, 3'd4, 1'b1), 1'b1);
        wait_drain();
`endif
        send(32'h57575757, 3'd7, mk(32'h00000000, 3'd7, 1'b1), 1'b1);
        wait_drain();

        // Back-to-back burst: no back-pressure, fixed latency, in order.
        base = n_wait;
        for (int i = 0; i < 8; i++)
            send_model({8'(i), 24'($urandom())}, 3'($urandom_range(0, 7)), 1'b1);
        wait_drain();
        check("burst_in_ready_low_cycles", 64'(n_wait - base), 64'(0));

        // Stall: out_ready low for 5 cycles while 5 beats are offered.
        @(negedge clk);
        out_ready = 1'b0;
        base = n_acc;
        seen = 1'b0;
        fork
            begin
                for (int i = 0; i < 5; i++)
                    send_model($urandom(), 3'($urandom_range(0, 2)), 1'b0);
            end
            begin
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    #4;
                    if (!in_ready && !seen) begin
                        seen = 1'b1;
                        check("accepted_before_full", 64'(n_acc - base), 64'(3));
                    end
                end
                @(negedge clk);
                out_ready = 1'b1;
            end
        join
        check("in_ready_fell", 64'(seen), 64'(1));
        wait_drain();
        check("stall_all_accepted", 64'(n_acc - base), 64'(5));

        // Reset with two beats in flight: both are discarded.
        send_model(32'hDEADBEEF, 3'd1, 1'b0);
        send_model(32'h01234567, 3'd2, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        exp_q.delete();
        out_before = n_out;
        @(negedge clk);
        rst_n = 1'b1;
        #4;
        check("flush_out_valid", 64'(out_valid), 64'(0));
        check("flush_out_data", 64'(out_data), 64'(0));
        check("flush_in_ready", 64'(in_ready), 64'(1));
        repeat (8) @(negedge clk);
        #4;
        check("flush_no_ghost_beats", 64'(n_out - out_before), 64'(0));

        // Randomized traffic with random gaps and random back-pressure.
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    if ($urandom_range(0, 3) == 0) idle();
                    send_model($urandom(), 3'($urandom_range(0, 7)), 1'b0);
                end
                idle();
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(negedge clk);
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
